// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame/timing defaults and the serialiser state encoding,
// common to the transmitter and the matching receiver.
package spi_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_CLKDIV    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

endpackage

// File: rtl/spi_tx_master_if.sv
// Word handshake plus SPI pins of the transmitter; master = the transmitter,
// slave = the word producer / SPI receiver side.
interface spi_tx_master_if
  import spi_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH
);

  logic [DATAWIDTH-1:0] data_in;
  logic                 data_valid;
  logic                 ready;
  logic                 done;
  logic                 sclk;
  logic                 mosi;
  logic                 nsel;

  modport master (
    input  data_in, data_valid,
    output ready, done, sclk, mosi, nsel
  );

  modport slave (
    output data_in, data_valid,
    input  ready, done, sclk, mosi, nsel
  );

endinterface

// File: rtl/spi_tick_gen.sv
// Phase timer: tick_o marks the last clk cycle of a CLKDIV-long phase;
// restart_i reloads it so the next phase starts on the following cycle.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int CLKDIV = DEF_CLKDIV
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLKDIV + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = CNT_W'(CLKDIV - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_tx_master.sv
// SPI mode-0 transmit master, MSB first: serialises one captured word per frame
// with chip-select framing and a done pulse; all pin outputs are registered.
module spi_tx_master
  import spi_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int CLKDIV    = DEF_CLKDIV
) (
  input  logic              clk,
  input  logic              reset,
  spi_tx_master_if.master   bus
);

  localparam int BITS_W = $clog2(DATAWIDTH + 1);

  spi_state_e           state_q;
  logic [DATAWIDTH-1:0] sreg_q;
  logic [DATAWIDTH-1:0] sreg_shl;
  logic [BITS_W-1:0]    bits_q;
  logic                 ready_q, done_q, sclk_q, mosi_q, nsel_q;
  logic                 tick, restart;

  // Every state change reloads the phase timer, so each non-idle state is CLKDIV long.
  always_comb begin
    restart  = (state_q == ST_IDLE) ? bus.data_valid : tick;
    sreg_shl = sreg_q << 1;
  end

  spi_tick_gen #(.CLKDIV(CLKDIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      bits_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      nsel_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (bus.data_valid) begin
          state_q <= ST_SETUP;
          sreg_q  <= bus.data_in;
          bits_q  <= BITS_W'(DATAWIDTH - 1);
          ready_q <= 1'b0;
          nsel_q  <= 1'b0;
          mosi_q  <= bus.data_in[DATAWIDTH-1];
        end
        ST_SETUP: if (tick) begin
          state_q <= ST_HIGH;
          sclk_q  <= 1'b1;
        end
        ST_HIGH: if (tick) begin
          sclk_q <= 1'b0;
          // bits_q counts bits still to send after the one on mosi now.
          if (bits_q != '0) begin
            state_q <= ST_LOW;
            sreg_q  <= sreg_shl;
            mosi_q  <= sreg_shl[DATAWIDTH-1];
            bits_q  <= bits_q - BITS_W'(1);
          end else begin
            state_q <= ST_HOLD;
          end
        end
        ST_LOW: if (tick) begin
          state_q <= ST_HIGH;
          sclk_q  <= 1'b1;
        end
        ST_HOLD: if (tick) begin
          state_q <= ST_GAP;
          nsel_q  <= 1'b1;
          mosi_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_GAP: if (tick) begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.sclk  = sclk_q;
  assign bus.mosi  = mosi_q;
  assign bus.nsel  = nsel_q;

endmodule

// File: doc/spi_tx_master.md
SPI_TX_MASTER -- requirements
Module: spi_tx_master

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, frame length in bits.
REQ-002 SHALL have parameter CLKDIV, default 4, sclk half-period in clk cycles; legal range >= 1.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port data_in, input, DATAWIDTH, word to transmit.
REQ-007 SHALL have port data_valid, input, 1, request to send data_in.
REQ-008 SHALL have port ready, output, 1, block idle and able to accept a word.
REQ-009 SHALL have port done, output, 1, one-cycle pulse at end of frame.
REQ-010 SHALL have port sclk, output, 1, SPI clock to receiver.
REQ-011 SHALL have port mosi, output, 1, SPI serial data to receiver.
REQ-012 SHALL have port nsel, output, 1, active-low chip select to receiver.

Function
REQ-013 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first: mosi changes only while sclk low; receiver samples on sclk rising edge.
REQ-014 SHALL accept a word on a clk edge where ready=1 and data_valid=1, capturing data_in into a shift register; later data_in changes SHALL NOT affect the frame.
REQ-015 SHALL have states IDLE, SETUP, HIGH, LOW, HOLD, GAP; all except IDLE last exactly CLKDIV cycles.
REQ-016 IDLE: ready=1, nsel=1, sclk=0, mosi=0; on accept -> SETUP.
REQ-017 SETUP: nsel=0, sclk=0, mosi=bit DATAWIDTH-1; -> HIGH.
REQ-018 HIGH: sclk=1, mosi stable; -> LOW if bits remain, else -> HOLD.
REQ-019 LOW: sclk=0, mosi=next lower bit; -> HIGH.
REQ-020 HOLD: sclk=0, nsel=0; -> GAP.
REQ-021 GAP: nsel=1, sclk=0, mosi=0, ready=0; done=1 on first GAP cycle only; -> IDLE.
REQ-022 SHALL produce exactly DATAWIDTH sclk rising edges per frame; ready SHALL return high exactly (2*DATAWIDTH+2)*CLKDIV cycles after the accepting edge.
REQ-023 data_valid while ready=0 SHALL be ignored and not queued; data_valid held high SHALL start the next frame on the first IDLE cycle (minimum nsel-high gap CLKDIV+1 cycles).
REQ-024 All outputs SHALL be registered; sclk and nsel SHALL be glitch-free.
REQ-025 Half-period timing SHALL use a counter of width $clog2(CLKDIV+1), reloaded on each state change; bit counter width $clog2(DATAWIDTH+1).
REQ-026 CLKDIV=1 SHALL yield sclk = clk/2 with no skipped or merged phases.

Reset
REQ-027 Reset SHALL force state IDLE, ready=1, done=0, nsel=1, sclk=0, mosi=0, counters and shift register zero on the next clk edge.
REQ-028 Reset mid-frame SHALL abort the frame with no further sclk edges and no done pulse.

Structure
REQ-029 SHALL place state encoding and default DATAWIDTH/CLKDIV constants in shared package spi_pkg, common with the SPI receiver.
REQ-030 SHALL use one sub-module spi_tick_gen: CLKDIV counter emitting a one-cycle phase-end tick, restartable by the FSM.

Verification
REQ-031 DATAWIDTH=8, CLKDIV=4, send 0xA5 -> mosi at the 8 sclk rises = 1,0,1,0,0,1,0,1; done once; ready back after 72 cycles.
REQ-032 Loopback into tt_um_spi (DATAWIDTH=8), send 0x3C -> receiver data=0x3C with data_rdy asserted after nsel rises.
REQ-033 data_valid held high with 0xFF then 0x00 -> two frames, nsel high >= CLKDIV+1 cycles between, receiver gets 0xFF then 0x00.
REQ-034 Pulse data_valid with 0x11 during a 0xA5 frame -> ignored, only 0xA5 transmitted, one done pulse.
REQ-035 Reset asserted after third sclk rise -> next cycle nsel=1, sclk=0, mosi=0, ready=1, no done; following 0x5A frame correct.
REQ-036 CLKDIV=1, send 0x80 -> sclk period 2 clk cycles, 8 rises, ready back after 18 cycles.
